// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared constants for the pipeline-control chain.
// Defaults for control-word and register-address widths.
package pipe_ctrl_chain_pkg;

  localparam int PIPE_CTRL_W     = 8;
  localparam int PIPE_REG_ADDR_W = 5;
  localparam int FWD_SEL_RF      = 0;

endpackage

// File: rtl/pipe_ctrl_chain_stage_reg.sv
// One downstream pipeline stage register.
// Load takes new content, bubble forces valid low, kill clears a held stage.
module pipe_ctrl_chain_stage_reg
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load,
  input  logic                  bubble,
  input  logic                  kill,
  input  logic                  d_valid,
  input  logic [CTRL_W-1:0]     d_ctrl,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic                  d_reg_write,
  input  logic                  d_mem_read,
  output logic                  q_valid,
  output logic [CTRL_W-1:0]     q_ctrl,
  output logic [REG_ADDR_W-1:0] q_rd,
  output logic                  q_reg_write,
  output logic                  q_mem_read
);

  // Advance, insert a bubble (stale payload kept), or clear valid in place.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_valid     <= 1'b0;
      q_ctrl      <= '0;
      q_rd        <= '0;
      q_reg_write <= 1'b0;
      q_mem_read  <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid & ~bubble;
      if (!bubble) begin
        q_ctrl      <= d_ctrl;
        q_rd        <= d_rd;
        q_reg_write <= d_reg_write;
        q_mem_read  <= d_mem_read;
      end
    end else if (kill) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control chain from decode through NUM_STAGES stages: stall, flush,
// load-use hazard and forwarding select. Option: PIPE_PERF_CNT_EN.
module pipe_ctrl_chain
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             in_valid_i,
  input  logic [CTRL_W-1:0]                in_ctrl_i,
  input  logic [REG_ADDR_W-1:0]            in_rd_i,
  input  logic                             in_reg_write_i,
  input  logic                             in_mem_read_i,
  output logic                             in_ready_o,
  input  logic [REG_ADDR_W-1:0]            id_rs1_i,
  input  logic [REG_ADDR_W-1:0]            id_rs2_i,
  input  logic                             id_use_rs1_i,
  input  logic                             id_use_rs2_i,
  input  logic [NUM_STAGES-1:0]            stall_i,
  input  logic [NUM_STAGES-1:0]            flush_i,
  output logic [NUM_STAGES-1:0]            stage_valid_o,
  output logic [NUM_STAGES*CTRL_W-1:0]     stage_ctrl_o,
  output logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd_o,
  output logic [NUM_STAGES-1:0]            stage_reg_write_o,
  output logic                             load_use_hazard_o,
  output logic [SEL_W-1:0]                 fwd_sel_rs1_o,
  output logic [SEL_W-1:0]                 fwd_sel_rs2_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_stall_cycles_o,
  output logic [31:0]                      perf_flush_cnt_o
`endif
);

  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] s_valid;
  logic [NUM_STAGES-1:0] s_rw;
  logic [NUM_STAGES-1:0] s_mr;
  logic [NUM_STAGES-1:0] wr_ok;
  logic [CTRL_W-1:0]     s_ctrl [NUM_STAGES];
  logic [REG_ADDR_W-1:0] s_rd   [NUM_STAGES];
  logic                  rs1_hit0;
  logic                  rs2_hit0;
  logic                  unused_mr;

  // A stage holds if it or any later stage stalls.
  always_comb begin
    hold = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      hold[k] = |(stall_i >> k);
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic                  d_valid;
    logic [CTRL_W-1:0]     d_ctrl;
    logic [REG_ADDR_W-1:0] d_rd;
    logic                  d_rw;
    logic                  d_mr;
    logic                  bub;

    if (k == 0) begin : g_head
      assign d_valid = in_valid_i;
      assign d_ctrl  = in_ctrl_i;
      assign d_rd    = in_rd_i;
      assign d_rw    = in_reg_write_i;
      assign d_mr    = in_mem_read_i;
      assign bub     = ~in_ready_o;
    end else begin : g_body
      assign d_valid = s_valid[k-1];
      assign d_ctrl  = s_ctrl[k-1];
      assign d_rd    = s_rd[k-1];
      assign d_rw    = s_rw[k-1];
      assign d_mr    = s_mr[k-1];
      assign bub     = hold[k-1] | flush_i[k-1];
    end

    pipe_ctrl_chain_stage_reg #(
      .CTRL_W     (CTRL_W),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load        (~hold[k]),
      .bubble      (bub),
      .kill        (flush_i[k]),
      .d_valid     (d_valid),
      .d_ctrl      (d_ctrl),
      .d_rd        (d_rd),
      .d_reg_write (d_rw),
      .d_mem_read  (d_mr),
      .q_valid     (s_valid[k]),
      .q_ctrl      (s_ctrl[k]),
      .q_rd        (s_rd[k]),
      .q_reg_write (s_rw[k]),
      .q_mem_read  (s_mr[k])
    );

    assign stage_ctrl_o[k*CTRL_W +: CTRL_W]       = s_ctrl[k];
    assign stage_rd_o[k*REG_ADDR_W +: REG_ADDR_W] = s_rd[k];
    assign wr_ok[k] = s_valid[k] & s_rw[k] & (s_rd[k] != '0);
  end

  assign unused_mr         = s_mr[NUM_STAGES-1];
  assign stage_valid_o     = s_valid;
  assign stage_reg_write_o = s_valid & s_rw;

  assign rs1_hit0 = id_use_rs1_i & (s_rd[0] == id_rs1_i);
  assign rs2_hit0 = id_use_rs2_i & (s_rd[0] == id_rs2_i);

  assign load_use_hazard_o = wr_ok[0] & s_mr[0] & (rs1_hit0 | rs2_hit0);
  assign in_ready_o        = ~hold[0] & ~load_use_hazard_o;

  // Youngest matching writer wins; a load in EX cannot forward yet.
  always_comb begin
    fwd_sel_rs1_o = SEL_W'(FWD_SEL_RF);
    fwd_sel_rs2_o = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (wr_ok[k] && id_use_rs1_i && s_rd[k] == id_rs1_i)
        fwd_sel_rs1_o = (k == 0 && s_mr[0]) ? SEL_W'(FWD_SEL_RF)
                                            : SEL_W'(k + 1);
      if (wr_ok[k] && id_use_rs2_i && s_rd[k] == id_rs2_i)
        fwd_sel_rs2_o = (k == 0 && s_mr[0]) ? SEL_W'(FWD_SEL_RF)
                                            : SEL_W'(k + 1);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Count refused decode cycles and cycles where a flush kills something.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cycles_o <= '0;
      perf_flush_cnt_o    <= '0;
    end else begin
      if (in_valid_i && !in_ready_o)
        perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
      if (|(flush_i & s_valid))
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed table-driven bench for pipe_ctrl_chain (3 stages).
// Rows: drive decode, check same-cycle outputs, clock, check stages.
module tb_pipe_ctrl_chain;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic [7:0]  in_ctrl_i;
  logic [4:0]  in_rd_i;
  logic        in_reg_write_i;
  logic        in_mem_read_i;
  logic        in_ready_o;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic [2:0]  stall_i;
  logic [2:0]  flush_i;
  logic [2:0]  stage_valid_o;
  logic [23:0] stage_ctrl_o;
  logic [14:0] stage_rd_o;
  logic [2:0]  stage_reg_write_o;
  logic        load_use_hazard_o;
  logic [1:0]  fwd_sel_rs1_o;
  logic [1:0]  fwd_sel_rs2_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl_chain dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .in_valid_i        (in_valid_i),
    .in_ctrl_i         (in_ctrl_i),
    .in_rd_i           (in_rd_i),
    .in_reg_write_i    (in_reg_write_i),
    .in_mem_read_i     (in_mem_read_i),
    .in_ready_o        (in_ready_o),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_use_rs1_i      (id_use_rs1_i),
    .id_use_rs2_i      (id_use_rs2_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .stage_valid_o     (stage_valid_o),
    .stage_ctrl_o      (stage_ctrl_o),
    .stage_rd_o        (stage_rd_o),
    .stage_reg_write_o (stage_reg_write_o),
    .load_use_hazard_o (load_use_hazard_o),
    .fwd_sel_rs1_o     (fwd_sel_rs1_o),
    .fwd_sel_rs2_o     (fwd_sel_rs2_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_flush_cnt_o    (perf_flush_cnt_o)
`endif
  );

  typedef struct {
    logic       iv;
    logic [7:0] ctrl;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [2:0] stall;
    logic [2:0] flush;
    logic       e_rdy;
    logic       e_haz;
    logic [1:0] e_s1;
    logic [1:0] e_s2;
    logic [2:0] e_v;
    logic       chk2;
    logic [7:0] e_ctrl2;
    logic [4:0] e_rd2;
  } vec_t;

  vec_t tv [22];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid_i     = 1'b0;
    in_ctrl_i      = '0;
    in_rd_i        = '0;
    in_reg_write_i = 1'b0;
    in_mem_read_i  = 1'b0;
    id_rs1_i       = '0;
    id_rs2_i       = '0;
    id_use_rs1_i   = 1'b0;
    id_use_rs2_i   = 1'b0;
    stall_i        = '0;
    flush_i        = '0;
  endtask

  initial begin
    //        iv ctrl  rd rw mr rs1 u1 rs2 u2 stall   flush   rdy haz s1 s2 v      c2 ctrl2 rd2
    tv[0]  = '{1, 8'h11, 1, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b001, 0, 8'h00, 0};
    tv[1]  = '{1, 8'h12, 2, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b011, 0, 8'h00, 0};
    tv[2]  = '{1, 8'h13, 3, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b111, 1, 8'h11, 1};
    tv[3]  = '{1, 8'h14, 4, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b111, 1, 8'h12, 2};
    tv[4]  = '{1, 8'h15, 5, 1, 0, 3, 1, 2, 1, 3'b000, 3'b000, 1, 0, 2, 3, 3'b111, 1, 8'h13, 3};
    tv[5]  = '{1, 8'h20, 6, 1, 0, 0, 0, 0, 0, 3'b010, 3'b000, 0, 0, 0, 0, 3'b011, 0, 8'h00, 0};
    tv[6]  = '{1, 8'h20, 6, 1, 0, 0, 0, 0, 0, 3'b010, 3'b000, 0, 0, 0, 0, 3'b011, 0, 8'h00, 0};
    tv[7]  = '{1, 8'h20, 6, 1, 0, 5, 1, 0, 1, 3'b000, 3'b000, 1, 0, 1, 0, 3'b111, 1, 8'h14, 4};
    tv[8]  = '{1, 8'h30, 5, 1, 1, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b111, 1, 8'h15, 5};
    tv[9]  = '{1, 8'h31, 8, 1, 0, 5, 1, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0, 3'b110, 0, 8'h00, 0};
    tv[10] = '{1, 8'h31, 8, 1, 0, 5, 1, 0, 0, 3'b000, 3'b000, 1, 0, 2, 0, 3'b101, 0, 8'h00, 0};
    tv[11] = '{1, 8'h40, 7, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b011, 0, 8'h00, 0};
    tv[12] = '{1, 8'h41, 7, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b111, 1, 8'h31, 8};
    tv[13] = '{1, 8'h42, 9, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b111, 1, 8'h40, 7};
    tv[14] = '{0, 8'h00, 0, 0, 0, 0, 1, 7, 1, 3'b000, 3'b000, 1, 0, 0, 2, 3'b110, 1, 8'h41, 7};
    tv[15] = '{1, 8'h50, 0, 1, 1, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b101, 0, 8'h00, 0};
    tv[16] = '{0, 8'h00, 0, 0, 0, 0, 1, 9, 1, 3'b000, 3'b000, 1, 0, 0, 3, 3'b010, 0, 8'h00, 0};
    tv[17] = '{1, 8'h60, 10, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b101, 0, 8'h00, 0};
    tv[18] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0, 0, 0, 3'b000, 0, 8'h00, 0};
    tv[19] = '{1, 8'h61, 11, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b001, 0, 8'h00, 0};
    tv[20] = '{1, 8'h62, 12, 1, 0, 0, 0, 0, 0, 3'b001, 3'b001, 0, 0, 0, 0, 3'b000, 0, 8'h00, 0};
    tv[21] = '{1, 8'h62, 12, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b001, 0, 8'h00, 0};

    idle_inputs();
    rst_i = 1'b1;
    #12;
    check("rst valid", 32'(stage_valid_o), 32'h0);
    check("rst ctrl", stage_ctrl_o, 32'h0);
    check("rst rd", stage_rd_o, 32'h0);
    check("rst reg_write", 32'(stage_reg_write_o), 32'h0);
`ifdef PIPE_PERF_CNT_EN
    check("rst perf_stall", perf_stall_cycles_o, 32'h0);
    check("rst perf_flush", perf_flush_cnt_o, 32'h0);
`endif
    rst_i = 1'b0;
    #1;
    check("rst ready", 32'(in_ready_o), 32'h1);
    check("rst hazard", 32'(load_use_hazard_o), 32'h0);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 22; i++) begin
      in_valid_i     = tv[i].iv;
      in_ctrl_i      = tv[i].ctrl;
      in_rd_i        = tv[i].rd;
      in_reg_write_i = tv[i].rw;
      in_mem_read_i  = tv[i].mr;
      id_rs1_i       = tv[i].rs1;
      id_use_rs1_i   = tv[i].u1;
      id_rs2_i       = tv[i].rs2;
      id_use_rs2_i   = tv[i].u2;
      stall_i        = tv[i].stall;
      flush_i        = tv[i].flush;
      #2;
      check($sformatf("r%0d ready", i), 32'(in_ready_o), 32'(tv[i].e_rdy));
      check($sformatf("r%0d hazard", i), 32'(load_use_hazard_o), 32'(tv[i].e_haz));
      check($sformatf("r%0d sel_rs1", i), 32'(fwd_sel_rs1_o), 32'(tv[i].e_s1));
      check($sformatf("r%0d sel_rs2", i), 32'(fwd_sel_rs2_o), 32'(tv[i].e_s2));
      @(posedge clk_i);
      #1;
      check($sformatf("r%0d valid", i), 32'(stage_valid_o), 32'(tv[i].e_v));
      check($sformatf("r%0d reg_write", i), 32'(stage_reg_write_o), 32'(tv[i].e_v));
      if (tv[i].chk2) begin
        check($sformatf("r%0d ctrl2", i), 32'(stage_ctrl_o[23:16]), 32'(tv[i].e_ctrl2));
        check($sformatf("r%0d rd2", i), 32'(stage_rd_o[14:10]), 32'(tv[i].e_rd2));
      end
    end

`ifdef PIPE_PERF_CNT_EN
    check("perf_stall total", perf_stall_cycles_o, 32'd4);
    check("perf_flush total", perf_flush_cnt_o, 32'd2);
`endif

    idle_inputs();
    in_valid_i     = 1'b1;
    in_ctrl_i      = 8'h70;
    in_rd_i        = 5'd13;
    in_reg_write_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("pre-rst valid", 32'(stage_valid_o), 32'h3);
    #2;
    rst_i = 1'b1;
    #1;
    check("async rst valid", 32'(stage_valid_o), 32'h0);
    check("async rst ctrl", stage_ctrl_o, 32'h0);
    check("async rst rd", stage_rd_o, 32'h0);
`ifdef PIPE_PERF_CNT_EN
    check("async rst perf_stall", perf_stall_cycles_o, 32'h0);
    check("async rst perf_flush", perf_flush_cnt_o, 32'h0);
`endif
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #2;
    check("post-rst ready", 32'(in_ready_o), 32'h1);
    repeat (3) @(posedge clk_i);
    #1;
    check("post-rst valid", 32'(stage_valid_o), 32'h0);
    check("post-rst reg_write", 32'(stage_reg_write_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
